// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;
    localparam int DEFAULT_XLEN = 32;

    // Canonical no-op (addi x0, x0, 0) for any consumer that needs a bubble filler.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

    // True when a byte address is not word aligned.
    function automatic logic misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_checker.sv
// Structural invariants of the fetch sequencer: the queue is never pushed while
// full without a matching pop, and queued plus in-flight entries never exceed DEPTH.
module fetch_checker #(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             reset_n,
    input logic             push,
    input logic             pop,
    input logic             full,
    input logic [CNT_W-1:0] count,
    input logic             inflight
);

    localparam int OCC_W = CNT_W + 1;

    logic [OCC_W-1:0] occ_s;

    assign occ_s = OCC_W'(count) + OCC_W'(inflight);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop));

    a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (occ_s <= OCC_W'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries in program order.
// Pointers wrap modulo DEPTH, so DEPTH does not have to be a power of two.
// Flush empties the queue and takes priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Advance a pointer, wrapping at DEPTH rather than at a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // A pop needs a valid head; a push into a full queue only succeeds when the head leaves.
    always_comb begin
        pop_ok_s  = pop & ~flush & ~empty;
        push_ok_s = push & ~flush & (~full | pop_ok_s);
    end

    // Entry storage; cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, PC+4 sequencer, synchronous IMEM
// request port and an output queue feeding decode in program order.
// Supports decode back-pressure (if_valid/if_ready) and redirects that flush
// everything fetched so far and restart at a new PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}},
    parameter int               DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [XLEN-1:0]     if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic                misalign_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    // Queue entry sized for this instance's address width.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_w_t;

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  req_pc_r;
    logic             inflight_r;
    logic             misalign_err_r;

    entry_w_t         push_entry_s;
    entry_w_t         q_head_s;
    logic [CNT_W-1:0] q_count_s;
    logic             q_empty_s;
    logic             q_full_s;
    logic             push_s;
    logic             pop_s;
    logic             if_valid_s;
    logic             issue_s;
    logic [OCC_W-1:0] occ_s;

    // Handshake, issue and push decisions. Redirect suppresses issue, push and
    // pop in the same cycle. The issue test counts slots that will still be
    // taken after this cycle's pop, so the queue can never overflow. Issue is
    // also held off while reset is asserted so the strobe drops immediately.
    always_comb begin
        if_valid_s          = ~q_empty_s & ~redirect_valid;
        pop_s               = if_valid_s & if_ready;
        occ_s               = OCC_W'(q_count_s) + OCC_W'(inflight_r) - OCC_W'(pop_s);
        issue_s             = reset_n & ~redirect_valid & (occ_s < OCC_W'(DEPTH));
        push_s              = inflight_r & ~redirect_valid;
        push_entry_s.pc     = req_pc_r;
        push_entry_s.instr  = imem_rsp_data;
    end

    assign imem_req_valid = issue_s;
    assign imem_req_addr  = pc_r;
    assign if_valid       = if_valid_s;
    assign if_pc          = q_head_s.pc;
    assign if_instr       = q_head_s.instr;
    assign misalign_err   = misalign_err_r;

    // PC sequencer: redirect loads the word-aligned target, otherwise each
    // issue advances by one instruction (wrapping silently at the top of the
    // address space) and remembers which PC the pending response belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= {XLEN{1'b0}};
            inflight_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            pc_r       <= pc_r + XLEN'(PC_STEP);
            req_pc_r   <= pc_r;
            inflight_r <= 1'b1;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    // Sticky flag: set by any redirect to a target that is not word aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_err_r <= 1'b0;
        end else if (redirect_valid && misaligned(redirect_pc[1:0])) begin
            misalign_err_r <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_w_t)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (q_head_s),
        .count     (q_count_s),
        .empty     (q_empty_s),
        .full      (q_full_s)
    );

    fetch_checker #(
        .DEPTH (DEPTH)
    ) u_checker (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_s),
        .pop      (pop_s),
        .full     (q_full_s),
        .count    (q_count_s),
        .inflight (inflight_r)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A scoreboard queue of expected PCs is loaded
// whenever the fetch stream is (re)started and is drained by a monitor on every
// accepted instruction; directed checks cover latency, stall, redirect,
// misalignment, PC wrap (second instance) and asynchronous reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic [31:0] w_rsp_data;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;
    logic        w_misalign;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp_pc;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic        prev_stall;
    int          outstanding;
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err)
    );

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .imem_req_valid (w_req_valid),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_data  (w_rsp_data),
        .if_valid       (w_if_valid),
        .if_ready       (1'b1),
        .if_pc          (w_if_pc),
        .if_instr       (w_if_instr),
        .misalign_err   (w_misalign)
    );

    always #5 clk = ~clk;

    // imem_sync model: 256x32 array, registered read indexed by addr[9:2].
    always @(posedge clk) begin
        imem_rsp_data <= mem[imem_req_addr[9:2]];
        w_rsp_data    <= mem[w_req_addr[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_expected(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    // Monitor: scoreboard on accepted instructions, head stability while
    // stalled, no if_valid during redirect, and the outstanding-fetch bound.
    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else if (redirect_valid) begin
            check("if_valid_in_redirect", 64'(if_valid), 64'h0);
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_head_pc", 64'(if_pc), 64'(held_pc));
                check("stall_head_instr", 64'(if_instr), 64'(held_instr));
            end
            if (if_valid && if_ready) begin
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_errors++;
                    $error("FAIL sb_underflow: observed pc %h expected no further output", if_pc);
                end
                if (exp_q.size() > 0) begin
                    mon_exp_pc = exp_q.pop_front();
                    check("sb_pc", 64'(if_pc), 64'(mon_exp_pc));
                    check("sb_instr", 64'(if_instr), 64'(mem[mon_exp_pc[9:2]]));
                end
            end
            if (imem_req_valid) outstanding++;
            if (if_valid && if_ready) outstanding--;
            n_checks++;
            assert (outstanding <= DEPTH) else begin
                n_errors++;
                $error("FAIL outstanding_bound: observed %0d expected <= %0d", outstanding, DEPTH);
            end
            prev_stall = if_valid && !if_ready;
            held_pc    = if_pc;
            held_instr = if_instr;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0013_0000 + 32'(i);
        end
        mem[0] = 32'h00a0_0093;
        mem[1] = 32'h00b0_0113;
        mem[2] = 32'h00c0_0193;

        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        if_ready       = 1'b1;
        load_expected(32'h0000_0000, 64);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_valid", 64'(if_valid), 64'h0);
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_if_pc", 64'(if_pc), 64'h0);
        check("rst_if_instr", 64'(if_instr), 64'h0);
        check("rst_misalign", 64'(misalign_err), 64'h0);

        // Test 1: release and first fetches (cycle 0 is before the first edge)
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("c0_req_valid", 64'(imem_req_valid), 64'h1);
        check("c0_req_addr", 64'(imem_req_addr), 64'h0);
        check("c0_if_valid", 64'(if_valid), 64'h0);
        @(posedge clk); #1;
        check("c1_if_valid", 64'(if_valid), 64'h0);
        @(posedge clk); #1;
        check("c2_if_valid", 64'(if_valid), 64'h1);
        check("c2_if_pc", 64'(if_pc), 64'h0);
        check("c2_if_instr", 64'(if_instr), 64'h00a0_0093);
        check("wrap_c2_pc", 64'(w_if_pc), 64'hFFFF_FFF8);
        check("wrap_c2_valid", 64'(w_if_valid), 64'h1);
        @(posedge clk); #1;
        check("c3_if_pc", 64'(if_pc), 64'h4);
        check("c3_if_instr", 64'(if_instr), 64'h00b0_0113);
        check("wrap_c3_pc", 64'(w_if_pc), 64'hFFFF_FFFC);
        @(posedge clk); #1;
        check("c4_if_pc", 64'(if_pc), 64'h8);
        check("c4_if_instr", 64'(if_instr), 64'h00c0_0193);
        check("wrap_c4_pc", 64'(w_if_pc), 64'h0);
        check("wrap_c4_instr", 64'(w_if_instr), 64'h00a0_0093);

        // Test 2: stall cycles 4-9
        if_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("c9_if_valid", 64'(if_valid), 64'h1);
        check("c9_if_pc", 64'(if_pc), 64'h8);
        check("c9_req_valid", 64'(imem_req_valid), 64'h0);
        @(posedge clk); #1;
        if_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Test 3: redirect with a stale entry queued and a response in flight
        if_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        load_expected(32'h0000_0040, 64);
        #1;
        check("r3_if_valid_R", 64'(if_valid), 64'h0);
        check("r3_req_valid_R", 64'(imem_req_valid), 64'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        #1;
        check("r3_req_addr_R1", 64'(imem_req_addr), 64'h40);
        check("r3_req_valid_R1", 64'(imem_req_valid), 64'h1);
        check("r3_if_valid_R1", 64'(if_valid), 64'h0);
        @(posedge clk); #1;
        check("r3_if_valid_R2", 64'(if_valid), 64'h0);
        @(posedge clk); #1;
        check("r3_if_valid_R3", 64'(if_valid), 64'h1);
        check("r3_if_pc_R3", 64'(if_pc), 64'h40);
        check("r3_if_instr_R3", 64'(if_instr), 64'(mem[16]));
        check("r3_misalign", 64'(misalign_err), 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // Test 4: misaligned redirect, then legal ones; flag is sticky
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        load_expected(32'h0000_0040, 64);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("r4_misalign", 64'(misalign_err), 64'h1);
        check("r4_req_addr", 64'(imem_req_addr), 64'h40);
        repeat (2) @(posedge clk);
        #1;
        check("r4_if_pc_R3", 64'(if_pc), 64'h40);
        repeat (2) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        load_expected(32'h0000_0080, 64);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("r4b_if_pc_R3", 64'(if_pc), 64'h80);
        check("r4b_misalign_sticky", 64'(misalign_err), 64'h1);
        @(posedge clk); #1;
        // back-to-back redirects: the second wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        load_expected(32'h0000_0100, 64);
        @(posedge clk); #1;
        redirect_pc    = 32'h0000_0200;
        load_expected(32'h0000_0200, 64);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        check("r4c_req_addr", 64'(imem_req_addr), 64'h200);
        repeat (2) @(posedge clk);
        #1;
        check("r4c_if_pc_R3", 64'(if_pc), 64'h200);
        check("r4c_misalign_sticky", 64'(misalign_err), 64'h1);
        repeat (3) @(posedge clk);

        // Test 6: asynchronous reset pulse between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_if_valid", 64'(if_valid), 64'h0);
        check("ar_req_valid", 64'(imem_req_valid), 64'h0);
        check("ar_if_pc", 64'(if_pc), 64'h0);
        check("ar_misalign", 64'(misalign_err), 64'h0);
        check("ar_wrap_if_valid", 64'(w_if_valid), 64'h0);
        load_expected(32'h0000_0000, 64);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ar_c0_req_addr", 64'(imem_req_addr), 64'h0);
        check("ar_c0_req_valid", 64'(imem_req_valid), 64'h1);
        repeat (2) @(posedge clk);
        #1;
        check("ar_c2_if_valid", 64'(if_valid), 64'h1);
        check("ar_c2_if_pc", 64'(if_pc), 64'h0);
        check("ar_c2_wrap_pc", 64'(w_if_pc), 64'hFFFF_FFF8);
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
